uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Host-side receive front end: deserialises an asynchronous 8N1 serial line and buffers the received bytes in a small FIFO.
- Presents the bytes on a ready/valid byte stream that feeds the host-interface bridge's rx_ready/rx_valid/rx_data input directly.
- Absorbs host bursts while the bridge is stalled on bus transactions, and reports line errors through sticky flags.

Parameters:
CLOCK_HZ, 50_000_000, core clock frequency in Hz
BAUD, 115_200, serial bit rate
LOG2_DEPTH, 4, FIFO depth = 2**LOG2_DEPTH entries (min 1)

Ports:
clock  in  1  core clock, all logic on posedge
reset  in  1  synchronous, active-high
serial_in  in  1  asynchronous serial line, idle high
rx_ready  in  1  consumer accepts byte this cycle
rx_valid  out  1  FIFO non-empty, rx_data valid
rx_data  out  8  byte at FIFO head
fifo_count  out  LOG2_DEPTH+1  current occupancy
overrun  out  1  sticky: byte dropped because FIFO full
framing_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch (0 when macro off)
clear_errors  in  1  clears all sticky flags

Behaviour:
- Oversample tick: 16x BAUD. Divider = (CLOCK_HZ + 8*BAUD)/(16*BAUD); elaboration error if result < 1. Tick counter runs freely only while FSM not IDLE; reloaded on entry to START.
- serial_in passes through 2-flop synchroniser; both flops reset to 1. All FSM decisions use synchronised value.
- FSM states:
  - IDLE: synced line low -> START, tick phase = 0.
  - START: at 8th tick (mid start bit) sample. Low -> DATA, bit index 0. High -> IDLE (glitch rejected, nothing reported).
  - DATA: sample every 16 ticks; shift in LSB first. After bit 7 -> STOP (-> PARITY when macro on).
  - STOP: sample after 16 ticks.
    - High -> push byte, -> IDLE.
    - Low -> framing_err=1, byte discarded, -> BREAK.
  - BREAK: wait for synced line high, then -> IDLE. No bytes assembled during a long break.
- Push occurs in the cycle the stop bit is sampled. rx_valid rises the next cycle if the FIFO was empty (1-cycle latency from stop sample).
- FIFO:
  - Show-ahead: rx_valid = !empty; rx_data = head entry.
  - Pop when rx_valid & rx_ready. rx_ready while empty is ignored.
  - Push while full with no pop -> byte dropped, overrun=1, contents unchanged.
  - Push and pop in the same cycle while full -> both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle while count=1 -> pop old head, new byte becomes head, rx_valid stays 1.
  - Pointers are LOG2_DEPTH bits and wrap modulo depth. fifo_count = writes - reads, range 0..2**LOG2_DEPTH.
- Sticky flags: set by their event, cleared by clear_errors. A set and a clear in the same cycle -> flag ends at 1.
- Reset (any time, including mid-frame):
  - FSM -> IDLE; FIFO emptied; rx_valid=0, fifo_count=0, all flags 0, rx_data=0.
  - Synchroniser = 1, so the frame in progress is not completed. The next falling edge starts a new frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a PARITY state after DATA samples a 9th bit 16 ticks later.
  - Even parity over data+parity bit required. Mismatch -> parity_err=1 and byte discarded; STOP still checked and framing_err still applies.
- Undefined: no PARITY state; parity_err tied 0; frame is 8N1.

Test Plan:
- CLOCK_HZ=1_600_000, BAUD=100_000 (16 clocks/bit), rx_ready=1; send 0x61 ('a') -> exactly one rx_valid pulse carrying 0x61, 1 cycle after stop-bit sample; no flags.
- Line low for 4 clocks then high -> rx_valid stays 0, fifo_count=0, no flags; a following frame 0x72 is received correctly.
- Frame 0x55 with stop bit low, then line held low 40 bit times -> framing_err=1, no byte pushed; after line returns high, next 0xA5 is received.
- rx_ready=0, LOG2_DEPTH=4; send bytes 0x00..0x10 (17) -> fifo_count=16, overrun=1. Then rx_ready=1 drains 0x00..0x0F in order; 0x10 is absent.
- FIFO full, assert rx_ready so the pop lands in the stop-sample cycle of byte 0x99 -> count stays 16, overrun=0, 0x99 is last out.
- Assert reset at bit 4 of a frame -> rx_valid=0, fifo_count=0, flags cleared. The tail of that frame yields no byte; the next clean 0x3C is received.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err=1, no byte. Send 0x07 with parity bit 1 -> byte 0x07 delivered.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled serial receiver feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx_fifo #(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                serial_in,
  input  logic                rx_ready,
  output logic                rx_valid,
  output logic [7:0]          rx_data,
  output logic [LOG2_DEPTH:0] fifo_count,
  output logic                overrun,
  output logic                framing_err,
  output logic                parity_err,
  input  logic                clear_errors
);

  localparam int DIV   = (CLOCK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << LOG2_DEPTH;

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_fifo: BAUD too high for CLOCK_HZ");
  end
  if (LOG2_DEPTH < 1) begin : g_bad_depth
    $error("uart_rx_fifo: LOG2_DEPTH must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic sync1;
  logic rxd;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxd   <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rxd   <= sync1;
    end
  end

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [3:0]    phase;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          tick;
  logic          mid;
  logic          bit_end;
  logic          stop_smp;
  logic          push;
  logic          fr_set;
  logic          par_set;

  assign tick     = (state != S_IDLE) && (div_cnt == DW'(DIV - 1));
  assign mid      = tick && (phase == 4'd7);
  assign bit_end  = tick && (phase == 4'd15);
  assign stop_smp = (state == S_STOP) && bit_end;
  assign fr_set   = stop_smp && !rxd;
  assign push     = stop_smp && rxd && !par_bad;

`ifdef UART_RX_PARITY_EN
  assign par_set = (state == S_PARITY) && bit_end && (^{shreg, rxd});
`else
  assign par_set = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      phase   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      if (state == S_IDLE || div_cnt == DW'(DIV - 1)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (tick) begin
        phase <= phase + 4'd1;
      end
      unique case (state)
        S_IDLE: begin
          if (!rxd) begin
            state   <= S_START;
            phase   <= '0;
            div_cnt <= '0;
            par_bad <= 1'b0;
          end
        end
        S_START: begin
          // a start bit gone high by mid-bit is line noise
          if (mid) begin
            phase   <= '0;
            bit_idx <= '0;
            state   <= rxd ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg   <= {rxd, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            par_bad <= par_set;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            par_bad <= 1'b0;
            state   <= rxd ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (rxd) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]            mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH-1:0] rptr;
  logic                  full;
  logic                  pop;
  logic                  wr;

  assign rx_valid = (fifo_count != '0);
  assign full     = (fifo_count == (LOG2_DEPTH + 1)'(DEPTH));
  assign pop      = rx_valid && rx_ready;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts
  assign wr       = push && (!full || pop);
  assign rx_data  = rx_valid ? mem[rptr] : 8'h00;

  always_ff @(posedge clock) begin
    if (wr) begin
      mem[wptr] <= shreg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (wr && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!wr && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      overrun     <= (overrun && !clear_errors) || (push && full && !pop);
      framing_err <= (framing_err && !clear_errors) || fr_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (parity_err && !clear_errors) || par_set;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed serial frames at 16 clocks per bit.
// Build with +define+UART_RX_PARITY_EN to exercise 8E1 framing.
module tb_uart_rx_fifo;

  localparam int LD = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int STOP_S = 16 * NB - 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          serial_in = 1'b1;
  logic          rx_ready = 1'b0;
  logic          clear_errors = 1'b0;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [LD:0]   fifo_count;
  logic          overrun;
  logic          framing_err;
  logic          parity_err;

  uart_rx_fifo #(
    .CLOCK_HZ(1_600_000),
    .BAUD(100_000),
    .LOG2_DEPTH(LD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .serial_in(serial_in),
    .rx_ready(rx_ready),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .fifo_count(fifo_count),
    .overrun(overrun),
    .framing_err(framing_err),
    .parity_err(parity_err),
    .clear_errors(clear_errors)
  );

  always #5 clock = ~clock;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         vcnt = 0;
  logic [7:0] got_d[$];
  int         got_c[$];

  // log every accepted byte with the cycle it was handed over
  always @(negedge clock) begin
    if (rx_valid) vcnt++;
    if (rx_valid && rx_ready) begin
      got_d.push_back(rx_data);
      got_c.push_back(cyc);
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] peek_d(input int k);
    return (k < got_d.size()) ? {24'h0, got_d[k]} : 32'hDEAD;
  endfunction

  task automatic send(input logic [7:0] d, input logic stop, input int par,
                      input int pulse_at, input int cut_at);
    logic [10:0] fr;
`ifdef UART_RX_PARITY_EN
    fr = {stop, (par < 0) ? ^d : par[0], d, 1'b0};
`else
    fr = {1'b1, stop, d, 1'b0};
`endif
    for (int i = 0; i < 16 * NB; i++) begin
      if (cut_at >= 0 && i >= cut_at) break;
      serial_in = fr[i/16];
      if (pulse_at >= 0) rx_ready = (i == pulse_at);
      step(1);
    end
  endtask

  task automatic clr;
    clear_errors = 1'b1;
    step(1);
    clear_errors = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    step(3);
    reset = 1'b0;
    step(2);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_flags", 32'({overrun, framing_err, parity_err}), 0);

    rx_ready = 1'b1;
    got_d.delete();
    got_c.delete();
    vcnt = 0;
    s = cyc;
    send(8'h61, 1'b1, -1, -1, -1);
    step(4);
    chk("t1_n", 32'(got_d.size()), 1);
    chk("t1_data", peek_d(0), 'h61);
    chk("t1_lat", (got_c.size() > 0) ? got_c[0] - s : -1, STOP_S);
    chk("t1_pulses", vcnt, 1);
    chk("t1_flags", 32'({overrun, framing_err, parity_err}), 0);

    got_d.delete();
    vcnt = 0;
    serial_in = 1'b0;
    step(4);
    serial_in = 1'b1;
    step(30);
    chk("t2_valid", vcnt, 0);
    chk("t2_count", 32'(fifo_count), 0);
    chk("t2_flags", 32'({overrun, framing_err, parity_err}), 0);
    send(8'h72, 1'b1, -1, -1, -1);
    step(4);
    chk("t2_n", 32'(got_d.size()), 1);
    chk("t2_data", peek_d(0), 'h72);

    got_d.delete();
    send(8'h55, 1'b0, -1, -1, -1);
    step(16 * 40);
    chk("t3_ferr", 32'(framing_err), 1);
    chk("t3_nobyte", 32'(got_d.size()), 0);
    serial_in = 1'b1;
    step(32);
    send(8'hA5, 1'b1, -1, -1, -1);
    step(4);
    chk("t3_n", 32'(got_d.size()), 1);
    chk("t3_data", peek_d(0), 'hA5);
    chk("t3_sticky", 32'(framing_err), 1);
    clr();
    chk("t3_clear", 32'(framing_err), 0);

    rx_ready = 1'b0;
    got_d.delete();
    for (int b = 0; b < 17; b++) send(8'(b), 1'b1, -1, -1, -1);
    step(4);
    chk("t4_count", 32'(fifo_count), 16);
    chk("t4_ovr", 32'(overrun), 1);
    chk("t4_held", 32'(got_d.size()), 0);
    rx_ready = 1'b1;
    step(20);
    rx_ready = 1'b0;
    chk("t4_n", 32'(got_d.size()), 16);
    for (int k = 0; k < 16; k++) chk("t4_order", peek_d(k), k);
    chk("t4_empty", 32'(fifo_count), 0);
    clr();
    chk("t4_clear", 32'(overrun), 0);

    got_d.delete();
    for (int b = 0; b < 16; b++) send(8'(8'h80 + b), 1'b1, -1, -1, -1);
    chk("t5_full", 32'(fifo_count), 16);
    send(8'h99, 1'b1, -1, STOP_S - 1, -1);
    step(4);
    chk("t5_count", 32'(fifo_count), 16);
    chk("t5_ovr", 32'(overrun), 0);
    chk("t5_pop1", peek_d(0), 'h80);
    rx_ready = 1'b1;
    step(20);
    rx_ready = 1'b0;
    chk("t5_n", 32'(got_d.size()), 17);
    chk("t5_second", peek_d(1), 'h81);
    chk("t5_16th", peek_d(15), 'h8F);
    chk("t5_last", peek_d(16), 'h99);

    got_d.delete();
    send(8'h11, 1'b1, -1, -1, -1);
    send(8'h22, 1'b0, -1, -1, -1);
    serial_in = 1'b1;
    step(20);
    chk("t6_pre_count", 32'(fifo_count), 1);
    chk("t6_pre_ferr", 32'(framing_err), 1);
    send(8'hF0, 1'b1, -1, -1, 88);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t6_valid", 32'(rx_valid), 0);
    chk("t6_count", 32'(fifo_count), 0);
    chk("t6_data", 32'(rx_data), 0);
    chk("t6_flags", 32'({overrun, framing_err, parity_err}), 0);
    serial_in = 1'b1;
    step(16 * NB);
    chk("t6_tail", 32'(fifo_count), 0);
    rx_ready = 1'b1;
    send(8'h3C, 1'b1, -1, -1, -1);
    step(4);
    chk("t6_n", 32'(got_d.size()), 1);
    chk("t6_next", peek_d(0), 'h3C);

`ifdef UART_RX_PARITY_EN
    got_d.delete();
    send(8'h07, 1'b1, 0, -1, -1);
    step(4);
    chk("par_err", 32'(parity_err), 1);
    chk("par_drop", 32'(got_d.size()), 0);
    chk("par_ferr", 32'(framing_err), 0);
    send(8'h07, 1'b1, 1, -1, -1);
    step(4);
    chk("par_n", 32'(got_d.size()), 1);
    chk("par_data", peek_d(0), 'h07);
`else
    chk("par_tied", 32'(parity_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
